avalon_csr_responder: RTL and testbench

// - Avalon-MM slave-side responder: a CSR register bank that terminates the avalon_bus slave end.
// - Sits behind the interconnect. Accepts single-word rd/wr with wait states, byte enables and

---
 rtl/avalon_csr_responder.sv | 190 +++++++++++++++++++
 tb/tb_avalon_csr_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_csr_responder.sv
// Avalon-MM slave CSR bank with programmable wait states, byte enables and error responses.
// Optional error-status register at index NUM_REGS when AVALON_CSR_ERR_STATUS_EN is defined.
module avalon_csr_responder #(
  parameter int unsigned         AWIDTH      = 20,
  parameter int unsigned         DWIDTH      = 32,
  parameter int unsigned         BE_WIDTH    = 4,
  parameter int unsigned         NUM_REGS    = 16,
  parameter int unsigned         WAIT_STATES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AWIDTH-1:0]            addr,
  input  logic [BE_WIDTH-1:0]          byte_enable,
  input  logic [DWIDTH-1:0]            wdata,
  input  logic                         wr,
  input  logic                         rd,
  input  logic                         lock,
  output logic [DWIDTH-1:0]            rdata,
  output logic                         rdata_valid,
  output logic [1:0]                   response,
  output logic                         wait_request,
  output logic [NUM_REGS*DWIDTH-1:0]   reg_q,
  input  logic [NUM_REGS*DWIDTH-1:0]   ro_data
);

  localparam logic [1:0] RESP_OKAY     = 2'd0;
  localparam logic [1:0] RESP_SLV_ERR  = 2'd2;
  localparam logic [1:0] RESP_DEC_ERR  = 2'd3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCEPT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int unsigned LSB = $clog2(BE_WIDTH);
  localparam int unsigned RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
`ifdef AVALON_CSR_ERR_STATUS_EN
  localparam int unsigned DECODE_LIMIT = NUM_REGS + 1;
`else
  localparam int unsigned DECODE_LIMIT = NUM_REGS;
`endif

  if (!(DWIDTH == 8 || DWIDTH == 16 || DWIDTH == 32 || DWIDTH == 64 || DWIDTH == 128))
    begin : g_bad_dwidth
      $fatal(1, "avalon_csr_responder: illegal DWIDTH");
    end
  if (BE_WIDTH != DWIDTH / 8) begin : g_bad_be_width
    $fatal(1, "avalon_csr_responder: BE_WIDTH must equal DWIDTH/8");
  end

  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DWIDTH-1:0]       rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic [DWIDTH-1:0]       regs_q [NUM_REGS];

  logic [AWIDTH-LSB-1:0]   idx;
  logic [RIW-1:0]          ridx;
  logic                    in_range;
  logic                    is_status;
  logic                    accept;
  logic                    wr_only;
  logic                    wr_commit;
  logic [1:0]              acc_resp;
  logic [DWIDTH-1:0]       acc_rdata;
  logic                    unused_ok;

  assign idx       = addr[AWIDTH-1:LSB];
  assign ridx      = idx[RIW-1:0];
  assign in_range  = 32'(idx) < DECODE_LIMIT;
  assign is_status = 32'(idx) == NUM_REGS;
  assign accept    = (state_q == S_ACCEPT);
  assign wr_only   = wr && !rd;
  assign wr_commit = accept && wr_only && in_range && !is_status && !RO_MASK[ridx];
  assign unused_ok = ^{lock, addr, ro_data};

`ifdef AVALON_CSR_ERR_STATUS_EN
  logic [7:0] err_cnt_q;
  logic       err_flag_q;
  logic       err_event;
  logic       err_clear;

  assign err_event = (response == RESP_SLV_ERR) || (response == RESP_DEC_ERR);
  assign err_clear = accept && wr_only && is_status && wdata[31] && byte_enable[3];

  // Clear has priority over a coincident error so the register reads back as zero.
  always_ff @(posedge clk) begin
    if (!rst || err_clear) begin
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else if (err_event) begin
      err_flag_q <= 1'b1;
      if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`endif

  always_comb begin
    acc_resp  = RESP_OKAY;
    acc_rdata = '0;
    if (rd && wr) begin
      acc_resp = RESP_SLV_ERR;
    end else if (!in_range) begin
      acc_resp = RESP_DEC_ERR;
`ifdef AVALON_CSR_ERR_STATUS_EN
    end else if (is_status) begin
      if (rd) acc_rdata = DWIDTH'({err_flag_q, 23'd0, err_cnt_q});
`endif
    end else if (RO_MASK[ridx]) begin
      if (wr) acc_resp = RESP_SLV_ERR;
      else    acc_rdata = ro_data[ridx*DWIDTH +: DWIDTH];
    end else if (rd) begin
      acc_rdata = regs_q[ridx];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    resp_d  = RESP_OKAY;
    case (state_q)
      S_IDLE: begin
        if (rd || wr) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACCEPT;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCEPT;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_ACCEPT: begin
        if (rd) begin
          state_d = S_RESP;
          rdata_d = acc_rdata;
          resp_d  = acc_resp;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++)
        if (byte_enable[b]) regs_q[ridx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i*DWIDTH +: DWIDTH] = regs_q[i];
  end

  // Write responses are combinational on the accept cycle; read responses ride with rdata_valid.
  always_comb begin
    response = RESP_OKAY;
    if (accept && wr_only)      response = acc_resp;
    else if (state_q == S_RESP) response = resp_q;
  end

  assign wait_request = !accept;
  assign rdata_valid  = (state_q == S_RESP);
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_avalon_csr_responder.sv
// Self-checking bench for avalon_csr_responder: directed steps plus random traffic against a
// transaction-level reference model. Honours AVALON_CSR_ERR_STATUS_EN when defined.
module tb_avalon_csr_responder;

  localparam int unsigned NREG = 16;
`ifdef AVALON_CSR_ERR_STATUS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [19:0]  addr;
  logic [3:0]   byte_enable;
  logic [31:0]  wdata;
  logic         wr, rd, lock;
  logic [31:0]  rdata;
  logic         rdata_valid;
  logic [1:0]   response;
  logic         wait_request;
  logic [511:0] reg_q;
  logic [511:0] ro_data;

  int tests = 0;
  int fails = 0;

  logic [31:0]  m_regs [NREG];
  logic [31:0]  m_ro   [NREG];
  logic [15:0]  m_ro_mask = 16'h0002;
  int unsigned  m_cnt;
  bit           m_flag;

  always #5 clk = ~clk;

  avalon_csr_responder #(
    .AWIDTH(20), .DWIDTH(32), .BE_WIDTH(4), .NUM_REGS(16),
    .WAIT_STATES(1), .RO_MASK(16'h0002)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .byte_enable(byte_enable), .wdata(wdata),
    .wr(wr), .rd(rd), .lock(lock), .rdata(rdata), .rdata_valid(rdata_valid),
    .response(response), .wait_request(wait_request), .reg_q(reg_q), .ro_data(ro_data)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
    m_cnt  = 0;
    m_flag = 1'b0;
  endfunction

  function automatic logic [511:0] model_vec();
    logic [511:0] v;
    for (int i = 0; i < NREG; i++) v[i*32 +: 32] = m_regs[i];
    return v;
  endfunction

  // Response codes: 0 OKAY, 2 SLAVE_ERROR, 3 DECODE_ERROR.
  task automatic model_txn(input logic r, input logic w, input logic [19:0] a,
                           input logic [3:0] b, input logic [31:0] wd,
                           output logic [1:0] resp, output logic [31:0] rdv);
    int unsigned idx;
    int unsigned limit;
    idx   = a / 4;
    limit = ERR_EN ? NREG + 1 : NREG;
    resp  = 2'd0;
    rdv   = 32'h0;
    if (r && w) begin
      resp = 2'd2;
    end else if (idx >= limit) begin
      resp = 2'd3;
    end else if (idx == NREG) begin
      if (r) rdv = {m_flag, 23'd0, 8'(m_cnt)};
      else if (wd[31] && b[3]) begin
        m_cnt  = 0;
        m_flag = 1'b0;
      end
    end else if (m_ro_mask[idx]) begin
      if (r) rdv = m_ro[idx];
      else   resp = 2'd2;
    end else if (r) begin
      rdv = m_regs[idx];
    end else begin
      for (int k = 0; k < 4; k++)
        if (b[k]) m_regs[idx][8*k +: 8] = wd[8*k +: 8];
    end
    if (ERR_EN && resp >= 2'd2) begin
      m_flag = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  // Entered just after a rising edge with the DUT idle; leaves it the same way.
  task automatic run(input string tag, input logic r, input logic w, input logic [19:0] a,
                     input logic [3:0] b, input logic [31:0] wd, output logic [31:0] obs_rd);
    logic [1:0]  eresp;
    logic [31:0] erd;
    int          n;
    bit          ok;
    model_txn(r, w, a, b, wd, eresp, erd);
    rd = r; wr = w; addr = a; byte_enable = b; wdata = wd;
    n  = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clk);
      n++;
      if (!wait_request) ok = 1'b1;
    end
    check({tag, "/accept_latency"}, n - 1, 2);
    check({tag, "/accept_resp"}, response, (w && !r) ? eresp : 2'd0);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    obs_rd = rdata;
    check({tag, "/rdata_valid"}, rdata_valid, r);
    check({tag, "/rdata"}, rdata, r ? erd : 32'h0);
    check({tag, "/read_resp"}, response, r ? eresp : 2'd0);
    check({tag, "/reg_q"}, reg_q, model_vec());
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] got;
    logic [19:0] ra;
    int unsigned sel;

    rst = 1'b0; rd = 1'b0; wr = 1'b0; lock = 1'b0;
    addr = '0; byte_enable = '0; wdata = '0;
    for (int i = 0; i < NREG; i++) begin
      m_ro[i] = $urandom;
      if (i == 1) m_ro[i] = 32'hCAFE0001;
      ro_data[i*32 +: 32] = m_ro[i];
    end
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/wait_request", wait_request, 1'b1);
    check("reset/rdata_valid", rdata_valid, 1'b0);
    check("reset/rdata", rdata, 32'h0);
    check("reset/response", response, 2'd0);
    check("reset/reg_q", reg_q, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    run("wr_reg2", 1'b0, 1'b1, 20'h8, 4'hF, 32'hDEADBEEF, got);
    check("wr_reg2/value", reg_q[95:64], 32'hDEADBEEF);
    run("rd_reg2", 1'b1, 1'b0, 20'h8, 4'h0, 32'h0, got);
    check("rd_reg2/value", got, 32'hDEADBEEF);
    run("lanes", 1'b0, 1'b1, 20'h8, 4'b0101, 32'h11223344, got);
    check("lanes/value", reg_q[95:64], 32'hDE22BE44);
    run("be_zero", 1'b0, 1'b1, 20'h8, 4'h0, 32'h55555555, got);
    run("unaligned_rd", 1'b1, 1'b0, 20'hB, 4'h0, 32'h0, got);
    check("unaligned_rd/value", got, 32'hDE22BE44);
    run("ro_wr", 1'b0, 1'b1, 20'h4, 4'hF, 32'h12345678, got);
    run("ro_rd", 1'b1, 1'b0, 20'h4, 4'h0, 32'h0, got);
    check("ro_rd/value", got, 32'hCAFE0001);
    run("rd_0x40", 1'b1, 1'b0, 20'h40, 4'h0, 32'h0, got);
    run("rd_far", 1'b1, 1'b0, 20'hFFFFC, 4'h0, 32'h0, got);
    run("wr_far", 1'b0, 1'b1, 20'h80, 4'hF, 32'hFFFFFFFF, got);
    run("rd_and_wr", 1'b1, 1'b1, 20'h8, 4'hF, 32'h0BADF00D, got);

    // Reset during the wait cycle of a read: the read must vanish.
    rd = 1'b1; addr = 20'h8;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd = 1'b0; rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midreset/rdata_valid", rdata_valid, 1'b0);
      check("midreset/wait_request", wait_request, 1'b1);
    end
    check("midreset/reg_q", reg_q, '0);
    @(posedge clk); #1;

`ifdef AVALON_CSR_ERR_STATUS_EN
    for (int e = 0; e < 3; e++) run("err_dec", 1'b1, 1'b0, 20'h80, 4'h0, 32'h0, got);
    run("status_rd", 1'b1, 1'b0, 20'h40, 4'h0, 32'h0, got);
    check("status_rd/value", got, 32'h80000003);
    run("status_noclr", 1'b0, 1'b1, 20'h40, 4'h7, 32'h80000000, got);
    run("status_clr", 1'b0, 1'b1, 20'h40, 4'h8, 32'h80000000, got);
    run("status_rd2", 1'b1, 1'b0, 20'h40, 4'h0, 32'h0, got);
    check("status_rd2/value", got, 32'h00000000);
    for (int e = 0; e < 260; e++) run("sat", 1'b0, 1'b1, 20'h4, 4'hF, 32'h0, got);
    run("status_sat", 1'b1, 1'b0, 20'h40, 4'h0, 32'h0, got);
    check("status_sat/value", got, 32'h800000FF);
`endif

    for (int t = 0; t < 200; t++) begin
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) ra = 20'($urandom);
      else ra = 20'(($urandom_range(0, 18) << 2) | $urandom_range(0, 3));
      run("random", (sel <= 4), (sel == 0 || sel >= 5), ra, 4'($urandom), $urandom, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
